// File: rtl/pkg_ampliacao.sv
// rtl/pkg_ampliacao.sv - shared types and limits for the 2x upscaler job sequencer
package pkg_ampliacao;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_RUN   = 3'd2,
        S_FIM   = 3'd3,
        S_ABORT = 3'd4
    } estado_t;

    localparam int LARGURA_MAX = 640;
    localparam int ALTURA_MAX  = 480;
    localparam int DIM_W       = 10;
    localparam int PIXEL_W     = 8;
    localparam int CONT_W      = 21;

    // Output pixel count of a 2x job: 4*W*H, fits 21 bits for 640x480.
    function automatic logic [CONT_W-1:0] total_saida(input logic [DIM_W-1:0] w,
                                                      input logic [DIM_W-1:0] h);
        logic [CONT_W-1:0] prod;
        prod = CONT_W'(w) * CONT_W'(h);
        return {prod[CONT_W-3:0], 2'b00};
    endfunction

endpackage

// File: rtl/controlador_ampliacao.sv
// rtl/controlador_ampliacao.sv - job sequencer feeding the nearest-neighbour core from/to RAM
module controlador_ampliacao
    import pkg_ampliacao::*;
#(
    parameter int ADDR_W   = 20,
    parameter int LARG_MAX = LARGURA_MAX,
    parameter int ALT_MAX  = ALTURA_MAX
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [DIM_W-1:0]   cmd_largura,
    input  logic [DIM_W-1:0]   cmd_altura,
    input  logic [ADDR_W-1:0]  cmd_src_base,
    input  logic [ADDR_W-1:0]  cmd_dst_base,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               erro,
    output logic               core_resetn,
    output logic               core_start,
    output logic [DIM_W-1:0]   core_largura,
    output logic [DIM_W-1:0]   core_altura,
    output logic [PIXEL_W-1:0] core_pixel_in,
    input  logic               core_pixel_in_ready,
    input  logic [PIXEL_W-1:0] core_pixel_out,
    input  logic               core_pixel_out_valid,
    input  logic               core_processing_done,
    output logic [ADDR_W-1:0]  src_rd_addr,
    input  logic [PIXEL_W-1:0] src_rd_data,
    output logic               dst_wr_en,
    output logic [ADDR_W-1:0]  dst_wr_addr,
    output logic [PIXEL_W-1:0] dst_wr_data
);

    estado_t             estado;
    logic [ADDR_W-1:0]   src_ptr;
    logic [ADDR_W-1:0]   dst_ptr;
    logic [CONT_W-1:0]   esperado;
    logic [CONT_W-1:0]   cont;
    logic [CONT_W-1:0]   cont_final;
    logic                cmd_invalido;

    assign cmd_invalido = (cmd_largura == '0) || (cmd_altura == '0) ||
                          (cmd_largura > DIM_W'(LARG_MAX)) || (cmd_altura > DIM_W'(ALT_MAX));

    // Reading one address ahead on a sampling cycle keeps the 1-cycle RAM latency hidden.
    assign src_rd_addr   = src_ptr + ADDR_W'(core_pixel_in_ready);
    assign core_pixel_in = src_rd_data;

    assign dst_wr_en   = (estado == S_RUN) && core_pixel_out_valid;
    assign dst_wr_addr = dst_ptr;
    assign dst_wr_data = core_pixel_out;
    assign cont_final  = cont + CONT_W'(dst_wr_en);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            estado       <= S_IDLE;
            cmd_ready    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            erro         <= 1'b0;
            core_resetn  <= 1'b0;
            core_start   <= 1'b0;
            core_largura <= '0;
            core_altura  <= '0;
            src_ptr      <= '0;
            dst_ptr      <= '0;
            esperado     <= '0;
            cont         <= '0;
        end else begin
            core_start  <= 1'b0;
            done        <= 1'b0;
            erro        <= 1'b0;
            core_resetn <= 1'b1;
            if (core_pixel_in_ready) begin
                src_ptr <= src_ptr + 1'b1;
            end
            if (dst_wr_en) begin
                dst_ptr <= dst_ptr + 1'b1;
                cont    <= cont_final;
            end
            case (estado)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        if (cmd_invalido) begin
                            erro <= 1'b1;
                        end else begin
                            core_largura <= cmd_largura;
                            core_altura  <= cmd_altura;
                            src_ptr      <= cmd_src_base;
                            dst_ptr      <= cmd_dst_base;
                            esperado     <= total_saida(cmd_largura, cmd_altura);
                            cont         <= '0;
                            core_start   <= 1'b1;
                            busy         <= 1'b1;
                            cmd_ready    <= 1'b0;
                            estado       <= S_START;
                        end
                    end
                end
                S_START, S_RUN: begin
                    // abort wins over a coincident processing_done
                    if (abort) begin
                        core_resetn <= 1'b0;
                        erro        <= 1'b1;
                        estado      <= S_ABORT;
                    end else if (estado == S_START) begin
                        estado <= S_RUN;
                    end else if (core_processing_done) begin
                        done   <= 1'b1;
                        erro   <= (cont_final != esperado);
                        estado <= S_FIM;
                    end
                end
                S_FIM, S_ABORT: begin
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    estado    <= S_IDLE;
                end
                default: begin
                    estado <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_ampliacao.sv
// tb/tb_controlador_ampliacao.sv - randomized directed bench with a behavioural core and RAM model
module tb_controlador_ampliacao;

    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          resetn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [9:0]    cmd_largura;
    logic [9:0]    cmd_altura;
    logic [AW-1:0] cmd_src_base;
    logic [AW-1:0] cmd_dst_base;
    logic          abort;
    logic          busy;
    logic          done;
    logic          erro;
    logic          core_resetn;
    logic          core_start;
    logic [9:0]    core_largura;
    logic [9:0]    core_altura;
    logic [7:0]    core_pixel_in;
    logic          core_pixel_in_ready;
    logic [7:0]    core_pixel_out;
    logic          core_pixel_out_valid;
    logic          core_processing_done;
    logic [AW-1:0] src_rd_addr;
    logic [7:0]    src_rd_data;
    logic          dst_wr_en;
    logic [AW-1:0] dst_wr_addr;
    logic [7:0]    dst_wr_data;

    int            checks = 0;
    int            errors = 0;
    logic [7:0]    semente;
    logic [7:0]    cap[$];
    bit            hold_next = 0;
    int            nx_w, nx_h;
    logic [AW-1:0] nx_src, nx_dst;

    always #5 clk = ~clk;

    controlador_ampliacao #(.ADDR_W(AW)) dut (
        .clk                 (clk),
        .resetn              (resetn),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_largura         (cmd_largura),
        .cmd_altura          (cmd_altura),
        .cmd_src_base        (cmd_src_base),
        .cmd_dst_base        (cmd_dst_base),
        .abort               (abort),
        .busy                (busy),
        .done                (done),
        .erro                (erro),
        .core_resetn         (core_resetn),
        .core_start          (core_start),
        .core_largura        (core_largura),
        .core_altura         (core_altura),
        .core_pixel_in       (core_pixel_in),
        .core_pixel_in_ready (core_pixel_in_ready),
        .core_pixel_out      (core_pixel_out),
        .core_pixel_out_valid(core_pixel_out_valid),
        .core_processing_done(core_processing_done),
        .src_rd_addr         (src_rd_addr),
        .src_rd_data         (src_rd_data),
        .dst_wr_en           (dst_wr_en),
        .dst_wr_addr         (dst_wr_addr),
        .dst_wr_data         (dst_wr_data)
    );

    function automatic logic [7:0] pix_of(input logic [AW-1:0] a);
        logic [AW-1:0] t;
        t = a * 20'h09E37;
        return t[12:5] ^ a[7:0] ^ semente;
    endfunction

    always @(posedge clk) src_rd_data <= pix_of(src_rd_addr);

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reject(input int w, input int h);
        cmd_valid = 1'b1; cmd_largura = 10'(w); cmd_altura = 10'(h);
        step();
        cmd_valid = 1'b0;
        #1;
        chk("rej_erro", erro, 1);
        chk("rej_start", core_start, 0);
        chk("rej_ready", cmd_ready, 1);
        chk("rej_busy", busy, 0);
        step(); #1;
        chk("rej_erro_clr", erro, 0);
        chk("rej_start2", core_start, 0);
    endtask

    task automatic run_job(input int w, input int h, input logic [AW-1:0] src,
                           input logic [AW-1:0] dst, input int abort_at, input int early_at);
        int n, total, k, oy, ox, idx;
        bit ok;
        logic [AW-1:0] a;
        n = w * h;
        total = 4 * n;
        cap.delete();
        cmd_valid = 1'b1; cmd_largura = 10'(w); cmd_altura = 10'(h);
        cmd_src_base = src; cmd_dst_base = dst;
        ok = 0;
        for (int t = 0; t < 20 && !ok; t++) begin
            step();
            if (core_start === 1'b1) ok = 1;
        end
        chk("start_seen", 32'(ok), 1);
        if (!ok) begin
            cmd_valid = 1'b0;
            return;
        end
        if (hold_next) begin
            cmd_largura = 10'(nx_w); cmd_altura = 10'(nx_h);
            cmd_src_base = nx_src; cmd_dst_base = nx_dst;
            hold_next = 0;
        end else begin
            cmd_valid = 1'b0;
        end
        #1;
        chk("start_busy", busy, 1);
        chk("start_ready", cmd_ready, 0);
        chk("lat_w", core_largura, w);
        chk("lat_h", core_altura, h);

        for (int i = 0; i < n; i++) begin
            step();
            core_pixel_in_ready = 1'b0;
            repeat ($urandom_range(0, 2)) step();
            core_pixel_in_ready = 1'b1;
            a = src + AW'(i);
            #1;
            chk("pixel_in", core_pixel_in, pix_of(a));
            cap.push_back(core_pixel_in);
        end
        step();
        core_pixel_in_ready = 1'b0;
        #1;
        chk("mid_busy", busy, 1);
        chk("mid_ready", cmd_ready, 0);
        chk("mid_restart", core_start, 0);

        for (k = 0; k < total; k++) begin
            step();
            core_pixel_out_valid = 1'b0; core_processing_done = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                #1;
                chk("gap_no_wr", dst_wr_en, 0);
                step();
            end
            oy = k / (2 * w); ox = k % (2 * w);
            idx = (oy / 2) * w + ox / 2;
            core_pixel_out = cap[idx];
            core_pixel_out_valid = 1'b1;
            if (k == total - 1 || k == early_at) core_processing_done = 1'b1;
            if (k == abort_at) begin
                abort = 1'b1;
                break;
            end
            #1;
            a = dst + AW'(k);
            chk("wr_en", dst_wr_en, 1);
            chk("wr_addr", dst_wr_addr, a);
            a = src + AW'(idx);
            chk("wr_data", dst_wr_data, pix_of(a));
            if (k == early_at) break;
        end
        step();
        core_pixel_out_valid = 1'b0; core_processing_done = 1'b0;

        if (abort_at >= 0 && abort_at < total) begin
            abort = 1'b0;
            core_pixel_out_valid = 1'b1;
            #1;
            chk("ab_core_rst", core_resetn, 0);
            chk("ab_erro", erro, 1);
            chk("ab_done", done, 0);
            chk("ab_no_wr", dst_wr_en, 0);
            step();
            core_pixel_out_valid = 1'b0;
            #1;
            chk("ab_rst_rel", core_resetn, 1);
            chk("ab_ready", cmd_ready, 1);
            chk("ab_done2", done, 0);
            chk("ab_busy", busy, 0);
            return;
        end

        #1;
        chk("done", done, 1);
        chk("done_erro", erro, (early_at >= 0) ? 1 : 0);
        chk("done_no_wr", dst_wr_en, 0);
        chk("done_no_start", core_start, 0);
        step(); #1;
        chk("done_clr", done, 0);
        chk("erro_clr", erro, 0);
        chk("end_ready", cmd_ready, 1);
        chk("end_busy", busy, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        semente = 8'($urandom);
        resetn = 1'b0; cmd_valid = 1'b0; cmd_largura = '0; cmd_altura = '0;
        cmd_src_base = '0; cmd_dst_base = '0; abort = 1'b0;
        core_pixel_in_ready = 1'b0; core_pixel_out = '0;
        core_pixel_out_valid = 1'b0; core_processing_done = 1'b0;
        repeat (2) step();
        #1;
        chk("rst_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_erro", erro, 0);
        chk("rst_core_rst", core_resetn, 0);
        chk("rst_start", core_start, 0);
        chk("rst_wr_en", dst_wr_en, 0);
        chk("rst_larg", core_largura, 0);
        chk("rst_src_addr", src_rd_addr, 0);
        chk("rst_dst_addr", dst_wr_addr, 0);
        step();
        resetn = 1'b1;
        step(); #1;
        chk("rel_ready", cmd_ready, 1);
        chk("rel_core_rst", core_resetn, 1);

        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        #1;
        chk("idle_abort_erro", erro, 0);
        chk("idle_abort_rst", core_resetn, 1);
        chk("idle_abort_ready", cmd_ready, 1);

        run_job(4, 2, 20'h00100, 20'h00800, -1, -1);
        reject(641, 2);
        reject(4, 0);
        reject(0, 4);
        reject(4, 481);
        run_job(8, 4, 20'hFFFF0, 20'hFFFF8, -1, -1);
        run_job(640, 1, 20'hFFF00, 20'h10000, -1, -1);
        run_job(1, 480, 20'hFFF00, 20'h20000, -1, -1);
        run_job(8, 8, 20'h00200, 20'h03000, 9, -1);
        run_job(2, 2, 20'h00300, 20'h04000, 15, -1);

        hold_next = 1; nx_w = 2; nx_h = 2; nx_src = 20'h00500; nx_dst = 20'h05010;
        run_job(3, 3, 20'h00400, 20'h05000, -1, -1);
        run_job(2, 2, 20'h00500, 20'h05010, -1, -1);

        run_job(4, 4, 20'h00600, 20'h06000, -1, 20);

        cmd_valid = 1'b1; cmd_largura = 10'd4; cmd_altura = 10'd4;
        cmd_src_base = 20'h00700; cmd_dst_base = 20'h07000;
        step();
        cmd_valid = 1'b0;
        step();
        resetn = 1'b0;
        #1;
        chk("midrst_core_rst", core_resetn, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_start", core_start, 0);
        step();
        resetn = 1'b1;
        step(); #1;
        chk("midrst_ready", cmd_ready, 1);
        chk("midrst_rel", core_resetn, 1);

        for (int r = 0; r < 4; r++) begin
            run_job($urandom_range(1, 6), $urandom_range(1, 6),
                    AW'($urandom), AW'($urandom), -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
